// File: rtl/if_fetch_unit_pkg.sv
// Shared constants, bus layouts and helpers for the IF fetch unit.
package if_fetch_unit_pkg;

  // Bus widths
  localparam int STALL_BUS_W = 6;
  localparam int BR_WD       = 33;
  localparam int IF_TO_ID_WD = 33;

  // Stall vector encoding: a set bit freezes the corresponding stage register
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // PC register value at reset; the first fetched address is RESET_PC + 4
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFBF_FFFC;

  // Instruction word substituted when ID is handed a bubble
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  // Branch bus driven by ID
  typedef struct packed {
    logic        br_e;
    logic [31:0] br_addr;
  } br_bus_t;

  // IF -> ID bus
  typedef struct packed {
    logic        ce;
    logic [31:0] pc;
  } if_to_id_t;

  // What the ID input register does at a given clock edge
  typedef enum logic [1:0] {
    HOLD_ADVANCE = 2'd0,  // IF/ID register loads a new PC
    HOLD_FREEZE  = 2'd1,  // IF/ID and ID/EX both frozen
    HOLD_BUBBLE  = 2'd2   // IF/ID frozen while ID/EX moves on: ID sees a nop
  } hold_op_e;

  // Classify an edge from {stall[2], stall[1]} (bit 0 = IF/ID, bit 1 = ID/EX)
  function automatic hold_op_e classify_hold(input logic [1:0] s);
    hold_op_e op;
    if (s[0] == NO_STOP) begin
      op = HOLD_ADVANCE;
    end else if (s[1] == STOP) begin
      op = HOLD_FREEZE;
    end else begin
      op = HOLD_BUBBLE;
    end
    return op;
  endfunction

  // Sequential successor of a PC; wraps modulo 2^32
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_unit_inst_hold_buf.sv
// Instruction hold buffer: keeps ID's instruction word stable while the
// IF/ID register is frozen, and substitutes a nop when ID receives a bubble.
// The SRAM keeps re-reading the (held) fetch PC during a stall, so its live
// output belongs to the next instruction, not to the one sitting in ID.
module inst_hold_buf
  import if_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic [1:0]  stall_hold,      // {stall[2], stall[1]}
  input  logic [31:0] inst_sram_rdata,
  output logic [31:0] id_inst
);

  logic        hold_v;
  logic [31:0] hold_inst;
  hold_op_e    hold_op;

  // Edge classification from the IF/ID and ID/EX stall bits
  always_comb begin
    hold_op = classify_hold(stall_hold);
  end

  // Capture the word on the first frozen edge, nop on a bubble, drop on advance
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_v    <= 1'b0;
      hold_inst <= 32'h0;
    end else begin
      case (hold_op)
        HOLD_ADVANCE: begin
          hold_v <= 1'b0;
        end
        HOLD_FREEZE: begin
          if (!hold_v) begin
            hold_inst <= inst_sram_rdata;
            hold_v    <= 1'b1;
          end
        end
        HOLD_BUBBLE: begin
          hold_inst <= NOP_INST;
          hold_v    <= 1'b1;
        end
        default: begin
          hold_v <= hold_v;
        end
      endcase
    end
  end

  // ID sees the held word while one is captured, otherwise the live SRAM data
  always_comb begin
    id_inst = hold_v ? hold_inst : inst_sram_rdata;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// IF-stage fetch unit: owns the PC, drives the instruction SRAM, sends
// {ce, pc} to ID and supplies ID with a stall-stable instruction word.
//
// Handshake: there is no ready signal toward ID. ce on if_to_id_bus is the
// valid bit for the pc beside it; the stall vector acts as the "not ready"
// back-pressure, and while stall[0] is set the {ce, pc} pair is held stable.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [STALL_BUS_W-1:0] stall,
  input  logic [BR_WD-1:0]       br_bus,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic                   inst_sram_en,
  output logic [3:0]             inst_sram_wen,
  output logic [31:0]            inst_sram_addr,
  output logic [31:0]            inst_sram_wdata,
  input  logic [31:0]            inst_sram_rdata,
  output logic [31:0]            id_inst
);

  br_bus_t     br;
  if_to_id_t   if_to_id;
  logic [31:0] pc_r;
  logic        ce_r;
  logic        pend_v;
  logic [31:0] pend_addr;
  logic [31:0] next_pc;
  logic        pc_stall;
  logic        unused_stall_hi;

  // Stages beyond ID/EX do not affect fetch
  assign unused_stall_hi = ^stall[STALL_BUS_W-1:3];

  // Unpack the branch bus and the PC stall bit
  always_comb begin
    br       = br_bus_t'(br_bus);
    pc_stall = (stall[0] == STOP);
  end

  // Next PC: a live branch beats a branch remembered during a stall
  always_comb begin
    if (br.br_e) begin
      next_pc = br.br_addr;
    end else if (pend_v) begin
      next_pc = pend_addr;
    end else begin
      next_pc = seq_pc(pc_r);
    end
  end

  // PC and fetch-enable register: advance when the PC stage is not stalled
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_r <= RESET_PC;
      ce_r <= 1'b0;
    end else if (!pc_stall) begin
      pc_r <= next_pc;
      ce_r <= 1'b1;
    end
  end

  // Pending branch: remember a target resolved while the PC is stalled
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_v    <= 1'b0;
      pend_addr <= 32'h0;
    end else if (!pc_stall) begin
      pend_v <= 1'b0;
    end else if (br.br_e) begin
      pend_v    <= 1'b1;
      pend_addr <= br.br_addr;
    end
  end

  // SRAM request and IF -> ID bus are straight register outputs
  always_comb begin
    inst_sram_en    = ce_r;
    inst_sram_wen   = 4'b0000;
    inst_sram_addr  = pc_r;
    inst_sram_wdata = 32'h0;
    if_to_id.ce     = ce_r;
    if_to_id.pc     = pc_r;
    if_to_id_bus    = if_to_id;
  end

  inst_hold_buf u_hold (
    .clk             (clk),
    .resetn          (resetn),
    .stall_hold      (stall[2:1]),
    .inst_sram_rdata (inst_sram_rdata),
    .id_inst         (id_inst)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a cycle table of stall/branch inputs with
// hand-computed PC and ID-instruction expectations, plus an asynchronous
// reset sequence applied mid-freeze.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC   = 32'hBFBF_FFFC;
  localparam logic [31:0] LOAD_PC  = 32'hBFC0_0100;
  localparam logic [31:0] LOAD_INS = 32'h8C22_0000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [5:0]  stall = 6'h0;
  logic [32:0] br_bus = 33'h0;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = 32'h0;
  logic [31:0] id_inst;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk             (clk),
    .resetn          (resetn),
    .stall           (stall),
    .br_bus          (br_bus),
    .if_to_id_bus    (if_to_id_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .id_inst         (id_inst)
  );

  // ---------------- SRAM model ----------------
  function automatic logic [31:0] word(input logic [31:0] a);
    return (a == LOAD_PC) ? LOAD_INS : (a ^ 32'h1357_9BDF);
  endfunction

  always @(posedge clk) begin
    inst_sram_rdata <= inst_sram_en ? word(inst_sram_addr) : 32'h0;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [32:0] got, input logic [32:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [5:0] s, input logic be, input logic [31:0] ba);
    stall  = s;
    br_bus = {be, ba};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [5:0]  stall;
    logic        br_e;
    logic [31:0] br_addr;
    logic        exp_ce;
    logic [31:0] exp_pc;
    logic [31:0] exp_id;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic [5:0] s, input logic be, input logic [31:0] ba,
                              input logic [31:0] pc, input logic [31:0] id);
    vec_t v;
    v.stall   = s;
    v.br_e    = be;
    v.br_addr = ba;
    v.exp_ce  = 1'b1;
    v.exp_pc  = pc;
    v.exp_id  = id;
    return v;
  endfunction

  initial begin
    // reset release, no stalls
    vecs[0]  = mk(6'h00, 1'b0, 32'h0,         32'hBFC0_0000, 32'h0);
    vecs[1]  = mk(6'h00, 1'b0, 32'h0,         32'hBFC0_0004, word(32'hBFC0_0000));
    vecs[2]  = mk(6'h00, 1'b0, 32'h0,         32'hBFC0_0008, word(32'hBFC0_0004));
    // unstalled branch
    vecs[3]  = mk(6'h00, 1'b1, 32'hBFC0_0100, 32'hBFC0_0100, word(32'hBFC0_0008));
    vecs[4]  = mk(6'h00, 1'b0, 32'h0,         32'hBFC0_0104, LOAD_INS);
    // freeze 3 cycles, branch in the 2nd; ID keeps the load word
    vecs[5]  = mk(6'h07, 1'b0, 32'h0,         32'hBFC0_0104, LOAD_INS);
    vecs[6]  = mk(6'h07, 1'b1, 32'hBFC0_0200, 32'hBFC0_0104, LOAD_INS);
    vecs[7]  = mk(6'h07, 1'b0, 32'h0,         32'hBFC0_0104, LOAD_INS);
    vecs[8]  = mk(6'h00, 1'b0, 32'h0,         32'hBFC0_0200, word(32'hBFC0_0104));
    vecs[9]  = mk(6'h00, 1'b0, 32'h0,         32'hBFC0_0204, word(32'hBFC0_0200));
    // overwrite variant: latest branch during the stall wins
    vecs[10] = mk(6'h07, 1'b0, 32'h0,         32'hBFC0_0204, word(32'hBFC0_0200));
    vecs[11] = mk(6'h07, 1'b1, 32'hBFC0_0200, 32'hBFC0_0204, word(32'hBFC0_0200));
    vecs[12] = mk(6'h07, 1'b1, 32'hBFC0_0300, 32'hBFC0_0204, word(32'hBFC0_0200));
    vecs[13] = mk(6'h00, 1'b0, 32'h0,         32'hBFC0_0300, word(32'hBFC0_0204));
    // live branch beats a pending one; pending then cleared
    vecs[14] = mk(6'h00, 1'b0, 32'h0,         32'hBFC0_0304, word(32'hBFC0_0300));
    vecs[15] = mk(6'h07, 1'b1, 32'hBFC0_0500, 32'hBFC0_0304, word(32'hBFC0_0300));
    vecs[16] = mk(6'h00, 1'b1, 32'hBFC0_0600, 32'hBFC0_0600, word(32'hBFC0_0304));
    vecs[17] = mk(6'h00, 1'b0, 32'h0,         32'hBFC0_0604, word(32'hBFC0_0600));
    // bubble: nop until advance
    vecs[18] = mk(6'h03, 1'b0, 32'h0,         32'hBFC0_0604, 32'h0);
    vecs[19] = mk(6'h03, 1'b0, 32'h0,         32'hBFC0_0604, 32'h0);
    vecs[20] = mk(6'h00, 1'b0, 32'h0,         32'hBFC0_0608, word(32'hBFC0_0604));
    vecs[21] = mk(6'h00, 1'b0, 32'h0,         32'hBFC0_060C, word(32'hBFC0_0608));
    // PC wrap at 2^32
    vecs[22] = mk(6'h00, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, word(32'hBFC0_060C));
    vecs[23] = mk(6'h00, 1'b0, 32'h0,         32'h0000_0000, word(32'hFFFF_FFFC));
  end

  // ---------------- test ----------------
  initial begin
    logic [31:0] held_word;
    #1;
    step();
    check("reset if_to_id_bus", if_to_id_bus, {1'b0, RST_PC});
    check("reset sram_en", {32'h0, inst_sram_en}, 33'h0);
    check("reset sram_wen", {29'h0, inst_sram_wen}, 33'h0);
    check("reset sram_wdata", {1'b0, inst_sram_wdata}, 33'h0);
    check("reset id_inst", {1'b0, id_inst}, {1'b0, inst_sram_rdata});
    step();
    resetn = 1'b1;
    check("post-release bus", if_to_id_bus, {1'b0, RST_PC});

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].stall, vecs[i].br_e, vecs[i].br_addr);
      step();
      check($sformatf("row%0d if_to_id_bus", i), if_to_id_bus, {vecs[i].exp_ce, vecs[i].exp_pc});
      check($sformatf("row%0d sram_addr", i), {inst_sram_en, inst_sram_addr}, {vecs[i].exp_ce, vecs[i].exp_pc});
      check($sformatf("row%0d id_inst", i), {1'b0, id_inst}, {1'b0, vecs[i].exp_id});
    end

    // Async reset mid-freeze with a captured word and a pending branch
    drive(6'h07, 1'b1, 32'hBFC0_0700);
    step();
    held_word = word(32'hFFFF_FFFC);
    check("freeze before reset id_inst", {1'b0, id_inst}, {1'b0, held_word});
    check("freeze before reset pc", if_to_id_bus, {1'b1, 32'h0000_0000});
    #2;
    drive(6'h00, 1'b0, 32'h0);
    resetn = 1'b0;
    #1;
    check("async reset bus", if_to_id_bus, {1'b0, RST_PC});
    check("async reset sram_en", {32'h0, inst_sram_en}, 33'h0);
    check("async reset id_inst live", {1'b0, id_inst}, {1'b0, word(32'h0000_0000)});
    step();
    #3;
    resetn = 1'b1;
    step();
    check("restart pc", if_to_id_bus, {1'b1, 32'hBFC0_0000});
    step();
    check("restart pc+4", if_to_id_bus, {1'b1, 32'hBFC0_0004});
    check("restart id_inst", {1'b0, id_inst}, {1'b0, word(32'hBFC0_0000)});

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
